// File: rtl/mrd_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mrd_mem_pkg (package)
//  Description : Shared types and constants for the DFT memory top and its
//                Source-stage output formatter: data/exponent widths, the
//                formatter FSM state type, the default FIFO entry layout and
//                a helper that maps a requested DFT length to a packet length.
//  Revision    : 1.0  initial release
// ============================================================================
package mrd_mem_pkg;

   // Native sample width of the memory top result path.
   localparam int c_data_w    = 18;
   // Native block-exponent width.
   localparam int c_exp_w     = 6;
   // DFT length field width.
   localparam int c_dftpts_w  = 12;
   // Default formatted output width.
   localparam int c_out_w     = 16;

   // Formatter framing state.
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fmt_state_t;

   // FIFO entry layout for the default configuration; the formatter builds
   // its own parameter-sized entry with exactly this field order.
   typedef struct packed {
      logic                  sop;
      logic                  eop;
      logic [c_exp_w-1:0]    ex;
      logic [c_out_w-1:0]    re;
      logic [c_out_w-1:0]    im;
   } fmt_entry_t;

   // A requested length of zero frames a single-sample packet.
   function automatic logic [c_dftpts_w-1:0] fmt_len(input logic [c_dftpts_w-1:0] n);
      return (n == '0) ? c_dftpts_w'(1) : n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mrd_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mrd_sync_fifo
//  Description : Single-clock FIFO with registered full/empty flags and a
//                registered head (no fall-through). Capacity is 2**AW
//                entries; the head register mirrors the oldest stored entry,
//                which keeps its slot until it is read.
//  Ports       : clk, rst_n (sync, active low)
//                i_wr_en/i_wr_data  write request (ignored while full)
//                o_full             registered full flag
//                i_rd_ready         consumer ready
//                o_rd_valid/o_rd_data registered head
//  Revision    : 1.0  initial release
// ============================================================================
module mrd_sync_fifo #(
   parameter int W  = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_wr_en,
   input  logic [W-1:0]  i_wr_data,
   output logic          o_full,
   input  logic          i_rd_ready,
   output logic          o_rd_valid,
   output logic [W-1:0]  o_rd_data
);

   localparam int c_depth = 1 << AW;

   logic [W-1:0]  mem_q [c_depth];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          head_valid_q, head_valid_d;
   logic [W-1:0]  head_data_q, head_data_d;
   logic          wr, rd;

   always_comb begin
      wr = i_wr_en & ~full_q;
      rd = head_valid_q & i_rd_ready;

      wr_ptr_d = wr_ptr_q + AW'(wr);
      rd_ptr_d = rd_ptr_q + AW'(rd);
      count_d  = count_q + (AW+1)'(wr) - (AW+1)'(rd);
      full_d   = (count_d == (AW+1)'(c_depth));
      empty_d  = (count_d == '0);

      // The head only ever shows entries that were stored before this edge,
      // so a write into an empty FIFO surfaces one cycle later.
      head_valid_d = rd ? (count_q > (AW+1)'(1)) : ~empty_q;
      head_data_d  = head_valid_d ? mem_q[rd_ptr_d] : head_data_q;
   end

   always_ff @(posedge clk) begin
      if (wr) begin
         mem_q[wr_ptr_q] <= i_wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         full_q       <= 1'b0;
         empty_q      <= 1'b1;
         head_valid_q <= 1'b0;
         head_data_q  <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         full_q       <= full_d;
         empty_q      <= empty_d;
         head_valid_q <= head_valid_d;
         head_data_q  <= head_data_d;
      end
   end

   assign o_full     = full_q;
   assign o_rd_valid = head_valid_q;
   assign o_rd_data  = head_data_q;

endmodule
`default_nettype wire

// File: rtl/mrd_source_fmt.sv
`default_nettype none
// ============================================================================
//  Module      : mrd_source_fmt
//  Description : Output formatter behind the DFT memory top Source stage.
//                Frames the valid/real/imag/exp stream into sop/eop packets
//                of dftpts samples, rescales each component with
//                round-half-up and saturation, and buffers the result in a
//                FIFO so the consumer may apply ready backpressure. The
//                source cannot stall, so a full FIFO drops the sample and
//                raises a sticky ovf_drop.
//  Ports       : clk, rst_n (sync, active low)
//                dftpts, in_valid, in_real, in_imag, in_exp   source side
//                out_ready, out_valid, out_sop, out_eop,
//                out_real, out_imag, out_exp                  stream side
//                busy, ovf_drop, sat_flag                     status
//  Revision    : 1.0  initial release
// ============================================================================
module mrd_source_fmt
   import mrd_mem_pkg::*;
#(
   parameter int IN_W    = c_data_w,
   parameter int OUT_W   = 16,
   parameter int RSHIFT  = 2,
   parameter int EXP_W   = c_exp_w,
   parameter int FIFO_AW = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [11:0]           dftpts,
   input  logic                  in_valid,
   input  logic [IN_W-1:0]       in_real,
   input  logic [IN_W-1:0]       in_imag,
   input  logic [EXP_W-1:0]      in_exp,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic                  out_sop,
   output logic                  out_eop,
   output logic [OUT_W-1:0]      out_real,
   output logic [OUT_W-1:0]      out_imag,
   output logic [EXP_W-1:0]      out_exp,
   output logic                  busy,
   output logic                  ovf_drop,
   output logic                  sat_flag
);

   typedef struct packed {
      logic               sop;
      logic               eop;
      logic [EXP_W-1:0]   ex;
      logic [OUT_W-1:0]   re;
      logic [OUT_W-1:0]   im;
   } entry_t;

   localparam int c_entry_w  = $bits(entry_t);
   localparam int c_max_i    = (1 << (OUT_W-1)) - 1;
   localparam int c_round_i  = (RSHIFT > 0) ? (1 << ((RSHIFT > 0) ? RSHIFT-1 : 0)) : 0;
   localparam logic signed [IN_W:0] c_max   = (IN_W+1)'(c_max_i);
   localparam logic signed [IN_W:0] c_min   = (IN_W+1)'(-c_max_i - 1);
   localparam logic signed [IN_W:0] c_round = (IN_W+1)'(c_round_i);

   // ------------------------------------------------------------------
   // Packet framing
   // ------------------------------------------------------------------
   fmt_state_t       state_q, state_d;
   logic [11:0]      cnt_q, cnt_d;
   logic [11:0]      len_q, len_d;
   logic [EXP_W-1:0] exp_l_q, exp_l_d;
   logic [11:0]      len_now;
   logic             cur_sop, cur_eop;
   logic [EXP_W-1:0] cur_exp;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      exp_l_d = exp_l_q;
      len_now = fmt_len(dftpts);
      cur_sop = 1'b0;
      cur_eop = 1'b0;
      cur_exp = exp_l_q;
      case (state_q)
         IDLE: begin
            // The first sample uses the live length/exponent; they are
            // latched for the rest of the packet.
            cur_sop = 1'b1;
            cur_eop = (len_now == 12'd1);
            cur_exp = in_exp;
            if (in_valid) begin
               len_d   = len_now;
               exp_l_d = in_exp;
               if (len_now != 12'd1) begin
                  state_d = RUN;
                  cnt_d   = 12'd1;
               end else begin
                  cnt_d   = 12'd0;
               end
            end
         end
         RUN: begin
            cur_eop = (cnt_q == len_q - 12'd1);
            if (in_valid) begin
               if (cur_eop) begin
                  state_d = IDLE;
                  cnt_d   = 12'd0;
               end else begin
                  cnt_d   = cnt_q + 12'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 12'd0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Rounding and saturation, one instance per component
   // ------------------------------------------------------------------
   logic [IN_W-1:0]  comp_in  [2];
   logic [OUT_W-1:0] comp_out [2];
   logic             comp_sat [2];

   assign comp_in[0] = in_real;
   assign comp_in[1] = in_imag;

   for (genvar gi = 0; gi < 2; gi++) begin : g_comp
      logic signed [IN_W:0] ext;
      logic signed [IN_W:0] sum;
      logic signed [IN_W:0] shr;

      // One guard bit keeps the rounding add from wrapping at the top.
      always_comb begin
         ext          = {comp_in[gi][IN_W-1], comp_in[gi]};
         sum          = ext + c_round;
         shr          = sum >>> RSHIFT;
         comp_sat[gi] = 1'b0;
         comp_out[gi] = shr[OUT_W-1:0];
         if (shr > c_max) begin
            comp_sat[gi] = 1'b1;
            comp_out[gi] = c_max[OUT_W-1:0];
         end else if (shr < c_min) begin
            comp_sat[gi] = 1'b1;
            comp_out[gi] = c_min[OUT_W-1:0];
         end
      end
   end

   // ------------------------------------------------------------------
   // Format register and sticky flags
   // ------------------------------------------------------------------
   logic   fmt_valid_q, fmt_valid_d;
   entry_t fmt_data_q, fmt_data_d;
   logic   sat_q, sat_d;
   logic   ovf_q, ovf_d;
   logic   fifo_full;

   always_comb begin
      fmt_valid_d = in_valid;
      fmt_data_d  = fmt_data_q;
      if (in_valid) begin
         fmt_data_d = '{sop: cur_sop,
                        eop: cur_eop,
                        ex:  cur_exp + EXP_W'(RSHIFT),
                        re:  comp_out[0],
                        im:  comp_out[1]};
      end
      sat_d = sat_q | (in_valid & (comp_sat[0] | comp_sat[1]));
      // Framing has already moved on for a dropped sample, so later
      // sop/eop tags stay on their true indices.
      ovf_d = ovf_q | (fmt_valid_q & fifo_full);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         len_q       <= '0;
         exp_l_q     <= '0;
         fmt_valid_q <= 1'b0;
         fmt_data_q  <= '0;
         sat_q       <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         exp_l_q     <= exp_l_d;
         fmt_valid_q <= fmt_valid_d;
         fmt_data_q  <= fmt_data_d;
         sat_q       <= sat_d;
         ovf_q       <= ovf_d;
      end
   end

   // ------------------------------------------------------------------
   // Output buffer
   // ------------------------------------------------------------------
   logic [c_entry_w-1:0] head_raw;
   entry_t               head;

   mrd_sync_fifo #(
      .W  (c_entry_w),
      .AW (FIFO_AW)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_wr_en    (fmt_valid_q),
      .i_wr_data  (fmt_data_q),
      .o_full     (fifo_full),
      .i_rd_ready (out_ready),
      .o_rd_valid (out_valid),
      .o_rd_data  (head_raw)
   );

   assign head     = head_raw;
   assign out_sop  = head.sop;
   assign out_eop  = head.eop;
   assign out_exp  = head.ex;
   assign out_real = head.re;
   assign out_imag = head.im;
   assign busy     = (state_q == RUN);
   assign ovf_drop = ovf_q;
   assign sat_flag = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_mrd_source_fmt.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mrd_source_fmt
//  Description : Self-checking bench for mrd_source_fmt. A packet/queue
//                model predicts every output cycle; directed tests pin the
//                model with hand-computed values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mrd_source_fmt;

   localparam int RSHIFT = 2;
   localparam int DEPTH  = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] dftpts = '0;
   logic        in_valid = 1'b0;
   logic [17:0] in_real = '0;
   logic [17:0] in_imag = '0;
   logic [5:0]  in_exp = '0;
   logic        out_ready = 1'b0;
   logic        out_valid, out_sop, out_eop, busy, ovf_drop, sat_flag;
   logic [15:0] out_real, out_imag;
   logic [5:0]  out_exp;

   always #5 clk = ~clk;

   mrd_source_fmt #(
      .IN_W(18), .OUT_W(16), .RSHIFT(RSHIFT), .EXP_W(6), .FIFO_AW(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .dftpts(dftpts), .in_valid(in_valid),
      .in_real(in_real), .in_imag(in_imag), .in_exp(in_exp),
      .out_ready(out_ready), .out_valid(out_valid), .out_sop(out_sop),
      .out_eop(out_eop), .out_real(out_real), .out_imag(out_imag),
      .out_exp(out_exp), .busy(busy), .ovf_drop(ovf_drop), .sat_flag(sat_flag)
   );

   typedef struct {
      bit         sop;
      bit         eop;
      logic [5:0] ex;
      int         re;
      int         im;
      int         wc;
   } ent_t;

   ent_t q[$];
   ent_t rx[$];
   ent_t pend;
   bit   pend_v = 0;
   int   idx = 0;
   int   len = 1;
   logic [5:0] pkt_exp = '0;
   bit   exp_sat = 0;
   bit   exp_ovf = 0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   prev_stall = 0;
   ent_t prev;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Spec arithmetic: add half an LSB, floor-divide by 2**RSHIFT, clip.
   function automatic int fmt_val(input int x, output bit s);
      int t;
      t = (x + (1 << (RSHIFT-1))) >>> RSHIFT;
      s = 0;
      if (t > 32767)  begin t = 32767;  s = 1; end
      if (t < -32768) begin t = -32768; s = 1; end
      return t;
   endfunction

   // Model and compare process; samples everything on the falling edge.
   always @(negedge clk) begin
      bit   exp_ov, full, s_re, s_im;
      ent_t e, a;
      cyc++;
      a.sop = out_sop; a.eop = out_eop; a.ex = out_exp;
      a.re = int'($signed(out_real)); a.im = int'($signed(out_imag)); a.wc = cyc;

      // An entry stored at the end of cycle wc is visible from cycle wc+2.
      exp_ov = (q.size() > 0) && (q[0].wc <= cyc - 2);
      chk("out_valid", out_valid, exp_ov);
      if (out_valid && q.size() > 0) begin
         chk("out_sop",  a.sop, q[0].sop);
         chk("out_eop",  a.eop, q[0].eop);
         chk("out_exp",  a.ex,  q[0].ex);
         chk("out_real", a.re,  q[0].re);
         chk("out_imag", a.im,  q[0].im);
      end
      if (prev_stall) begin
         chk("hold_valid", out_valid, 1);
         chk("hold_real",  a.re, prev.re);
         chk("hold_imag",  a.im, prev.im);
         chk("hold_flags", {a.sop, a.eop, a.ex}, {prev.sop, prev.eop, prev.ex});
      end
      chk("ovf_drop", ovf_drop, exp_ovf);
      chk("sat_flag", sat_flag, exp_sat);
      chk("busy",     busy,     idx != 0);

      prev_stall = out_valid && out_ready;
      prev_stall = out_valid && !out_ready;
      prev = a;

      if (!rst_n) begin
         q.delete();
         pend_v = 0; idx = 0; exp_sat = 0; exp_ovf = 0; prev_stall = 0;
      end else begin
         full = (q.size() == DEPTH);
         if (out_valid && out_ready) begin
            rx.push_back(a);
            if (q.size() > 0) void'(q.pop_front());
         end
         if (pend_v) begin
            if (full) exp_ovf = 1;
            else begin pend.wc = cyc; q.push_back(pend); end
         end
         pend_v = in_valid;
         if (in_valid) begin
            if (idx == 0) begin
               len = (dftpts == 0) ? 1 : int'(dftpts);
               pkt_exp = in_exp;
            end
            e.sop = (idx == 0);
            e.eop = (idx == len - 1);
            e.ex  = pkt_exp + 6'(RSHIFT);
            e.re  = fmt_val(int'($signed(in_real)), s_re);
            e.im  = fmt_val(int'($signed(in_imag)), s_im);
            e.wc  = 0;
            if (s_re || s_im) exp_sat = 1;
            idx = e.eop ? 0 : idx + 1;
            pend = e;
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic send(input int re, input int im);
      in_valid = 1'b1; in_real = 18'(re); in_imag = 18'(im);
      step();
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      in_valid = 1'b0; rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      rx.delete();
   endtask

   task automatic drain();
      int n = 0;
      in_valid = 1'b0;
      while ((q.size() != 0 || pend_v || out_valid) && n < 300) begin
         step(); n++;
      end
      step();
      chk("drain_timeout", n >= 300, 0);
   endtask

   initial begin
      int lat;
      int sops;
      int w;

      // Reset state
      step(); step();
      rst_n = 1'b1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_flags", {ovf_drop, sat_flag}, 0);
      chk("rst_payload", {out_sop, out_eop, out_exp, out_real, out_imag}, 0);

      // 1: 12-point packet, ready high, latency
      out_ready = 1'b1; dftpts = 12'd12; in_exp = 6'd0; rx.delete();
      lat = 0;
      for (int i = 0; i < 12; i++) begin
         send(8*i, -8*i);
         in_valid = (i < 11);
         if (lat == 0 && out_valid) lat = i + 1;
      end
      drain();
      chk("t1_latency", lat, 3);
      chk("t1_count", rx.size(), 12);
      if (rx.size() == 12) begin
         chk("t1_sop0", rx[0].sop, 1);
         chk("t1_eop11", rx[11].eop, 1);
         chk("t1_eop0", rx[0].eop, 0);
         for (int i = 0; i < 12; i++) begin
            chk("t1_real", rx[i].re, 2*i);
            chk("t1_imag", rx[i].im, -2*i);
         end
      end

      // 2: rounding and saturation
      do_reset();
      dftpts = 12'd4;
      send(6, 0); send(-6, 0);
      drain();
      chk("t2_sat_clear", sat_flag, 0);
      send(131071, -131072); send(0, 0);
      drain();
      chk("t2_sat_set", sat_flag, 1);
      chk("t2_count", rx.size(), 4);
      if (rx.size() == 4) begin
         chk("t2_round_pos", rx[0].re, 2);
         chk("t2_round_neg", rx[1].re, -1);
         chk("t2_sat_hi", rx[2].re, 32767);
         chk("t2_min", rx[2].im, -32768);
         chk("t2_eop3", rx[3].eop, 1);
      end

      // 3: overflow with ready low
      do_reset();
      out_ready = 1'b0; dftpts = 12'd12;
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1; in_real = 18'(4*i); in_imag = '0;
         step();
      end
      in_valid = 1'b0;
      repeat (4) step();
      chk("t3_ovf", ovf_drop, 1);
      out_ready = 1'b1;
      drain();
      chk("t3_count", rx.size(), 16);
      if (rx.size() == 16) begin
         chk("t3_sop0", rx[0].sop, 1);
         chk("t3_eop11", rx[11].eop, 1);
         chk("t3_sop12", rx[12].sop, 1);
         chk("t3_last", rx[15].re, 15);
      end

      // 4: back-to-back packets and a zero-length request
      do_reset();
      out_ready = 1'b1;
      dftpts = 12'd2; in_exp = 6'd5;
      in_valid = 1'b1; in_real = 18'd4; step();
      in_real = 18'd8; step();
      dftpts = 12'd3; in_exp = 6'h3E;
      in_real = 18'd12; step();
      in_exp = 6'd9;
      in_real = 18'd16; step();
      in_real = 18'd20; step();
      dftpts = 12'd0; in_exp = 6'd1;
      in_real = 18'd24; step();
      drain();
      chk("t4_count", rx.size(), 6);
      if (rx.size() == 6) begin
         chk("t4_exp", {rx[0].ex, rx[1].ex, rx[2].ex, rx[3].ex, rx[4].ex},
             {6'd7, 6'd7, 6'd0, 6'd0, 6'd0});
         chk("t4_sop", {rx[0].sop, rx[1].sop, rx[2].sop, rx[3].sop, rx[4].sop}, 5'b10100);
         chk("t4_eop", {rx[0].eop, rx[1].eop, rx[2].eop, rx[3].eop, rx[4].eop}, 5'b01001);
         chk("t4_len0", {rx[5].sop, rx[5].eop, rx[5].ex}, {2'b11, 6'd3});
      end

      // 5: long packet with random backpressure
      do_reset();
      dftpts = 12'd1296; in_exp = 6'd0;
      w = 4;
      for (int i = 0; i < 2*1296; i++) begin
         if (i % 4 == 0) w = $urandom_range(0, 4);
         out_ready = ((i % 4) != w);
         in_valid  = (i % 2 == 0);
         in_real   = 18'($urandom);
         in_imag   = 18'($urandom);
         step();
      end
      out_ready = 1'b1;
      drain();
      chk("t5_count", rx.size(), 1296);
      chk("t5_ovf", ovf_drop, 0);
      sops = 0;
      foreach (rx[i]) sops += rx[i].sop;
      chk("t5_sops", sops, 1);
      if (rx.size() == 1296) chk("t5_eop", rx[1295].eop, 1);

      // 6: reset mid-packet
      do_reset();
      out_ready = 1'b1; dftpts = 12'd60;
      for (int i = 0; i < 5; i++) send(131071, i);
      do_reset();
      chk("t6_out_valid", out_valid, 0);
      chk("t6_flags", {ovf_drop, sat_flag, busy}, 0);
      send(40, 0);
      drain();
      chk("t6_count", rx.size(), 1);
      if (rx.size() == 1) chk("t6_sop", {rx[0].sop, rx[0].eop}, 2'b10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
